// File: rtl/music_addr_sequencer_pkg.sv
// Shared types and default address bounds for the music address sequencer.
package music_pkg;

    typedef logic [22:0] addr_t;

    localparam addr_t DEF_START_ADDR = 23'h0;
    localparam addr_t DEF_END_ADDR   = 23'h7FFFF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        PLAY_FIRST,
        PLAY_SECOND,
        ADVANCE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/music_addr_sequencer_if.sv
// Avalon-MM read-only bus between the sequencer (master) and the flash controller (slave).
interface music_addr_sequencer_if;
    import music_pkg::*;

    logic        flash_read;
    addr_t       flash_address;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );

endinterface

// File: rtl/music_addr_sequencer_unpacker.sv
// Picks one 16-bit sample out of a packed word; playing backward reverses the order of the halves.
// Purely combinational, no latency, no flow control.
module sample_unpacker (
    input  logic [31:0] word,
    input  logic        forward,
    input  logic        second,
    output logic [15:0] sample
);

    // The low half is earlier in time, so it comes first forward and second backward.
    assign sample = (forward ^ second) ? word[15:0] : word[31:16];

endmodule

// File: rtl/music_addr_sequencer.sv
// Streams packed 16-bit samples from flash, one per accepted sample_tick (MUSIC_SEQ_LOOP_EN wraps at the bounds).
// Latency: audio_valid one cycle after the tick; a single Avalon read in flight, held while waitrequest is high.
// Backpressure: pause stalls ticks and new reads; a restart never aborts a read that is already on the bus.
module music_addr_sequencer
    import music_pkg::*;
#(
    parameter addr_t START_ADDR = DEF_START_ADDR,
    parameter addr_t END_ADDR   = DEF_END_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   rst_cmd,
    input  logic                   direction,
    input  logic                   pause,
    input  addr_t                  initial_address,
    music_addr_sequencer_if.master flash,
    output logic [15:0]            audio_data,
    output logic                   audio_valid,
    output logic                   done
);

`ifdef MUSIC_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    seq_state_t  state;
    addr_t       addr;
    logic [31:0] word;
    logic        restart_pend;
    logic        done_q;
    logic [15:0] sample;
    logic        at_boundary;
    logic        tick_ok;
    logic        restart_now;

    sample_unpacker u_unpack (
        .word    (word),
        .forward (direction),
        .second  (state == PLAY_SECOND),
        .sample  (sample)
    );

    assign at_boundary = direction ? (addr == END_ADDR) : (addr == START_ADDR);
    // Refusing a tick right after a strobe keeps audio_valid from firing on consecutive cycles.
    assign tick_ok     = sample_tick && !pause && !audio_valid;
    assign restart_now = restart_pend &&
                         (state inside {IDLE, PLAY_FIRST, PLAY_SECOND, ADVANCE, DONE});
    assign done        = LOOP_EN ? 1'b0 : done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            addr                <= START_ADDR;
            word                <= '0;
            restart_pend        <= 1'b0;
            done_q              <= 1'b0;
            audio_data          <= '0;
            audio_valid         <= 1'b0;
            flash.flash_read    <= 1'b0;
            flash.flash_address <= '0;
        end else begin
            audio_valid <= 1'b0;
            if (rst_cmd) begin
                restart_pend <= 1'b1;
            end

            if (restart_now) begin
                state        <= IDLE;
                addr         <= initial_address;
                done_q       <= 1'b0;
                restart_pend <= rst_cmd;
            end else begin
                case (state)
                    IDLE: begin
                        if (!pause) begin
                            state               <= REQ;
                            flash.flash_read    <= 1'b1;
                            flash.flash_address <= addr;
                        end
                    end
                    REQ: begin
                        if (!flash.flash_waitrequest) begin
                            state            <= WAIT_DATA;
                            flash.flash_read <= 1'b0;
                        end
                    end
                    WAIT_DATA: begin
                        // A restart requested mid-read lets the read finish and drops its data.
                        if (flash.flash_readdatavalid) begin
                            if (restart_pend) begin
                                state        <= IDLE;
                                addr         <= initial_address;
                                done_q       <= 1'b0;
                                restart_pend <= rst_cmd;
                            end else begin
                                word  <= flash.flash_readdata;
                                state <= PLAY_FIRST;
                            end
                        end
                    end
                    PLAY_FIRST: begin
                        if (tick_ok) begin
                            audio_data  <= sample;
                            audio_valid <= 1'b1;
                            state       <= PLAY_SECOND;
                        end
                    end
                    PLAY_SECOND: begin
                        if (tick_ok) begin
                            audio_data  <= sample;
                            audio_valid <= 1'b1;
                            state       <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        state <= IDLE;
                        if (!at_boundary) begin
                            addr <= direction ? addr + 23'd1 : addr - 23'd1;
                        end else if (LOOP_EN) begin
                            addr <= direction ? START_ADDR : END_ADDR;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_addr_sequencer.sv
// Bench for music_addr_sequencer: flash slave model, sample capture, and a word-list reference model.
module tb_music_addr_sequencer;

    localparam logic [22:0] START_A = 23'h0;
    localparam logic [22:0] END_A   = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic        rst_cmd;
    logic        direction;
    logic        pause;
    logic [22:0] initial_address;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        done;

    music_addr_sequencer_if flash_if ();

    music_addr_sequencer u_dut (
        .clk             (clk),
        .reset           (reset),
        .sample_tick     (sample_tick),
        .rst_cmd         (rst_cmd),
        .direction       (direction),
        .pause           (pause),
        .initial_address (initial_address),
        .flash           (flash_if),
        .audio_data      (audio_data),
        .audio_valid     (audio_valid),
        .done            (done)
    );

    always #5 clk = ~clk;

    int compared;
    int mismatched;

    int          wait_cfg = 0;
    int          lat_cfg  = 1;
    int          wcnt     = 0;
    int          lat_left = 0;
    int          rdv_count = 0;
    int          viol     = 0;
    bit          prev_valid = 1'b0;
    bit          prev_rd_wait = 1'b0;
    logic [22:0] prev_addr = '0;
    logic [22:0] acc_addr = '0;
    logic [22:0] acc_q[$];
    logic [15:0] got_q[$];
    logic [15:0] exp_s[$];
    logic [22:0] exp_a[$];
    logic [15:0] exp_last = '0;
    logic [31:0] mem[int];

    function automatic logic [31:0] word_at(input logic [22:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    // Reference: the sample stream is just each word's halves in play order, word after word.
    function automatic void build_exp(input logic [22:0] start, input bit fwd, input int nwords);
        logic [22:0] a;
        logic [31:0] w;
        a = start;
        exp_s.delete();
        exp_a.delete();
        for (int i = 0; i < nwords; i++) begin
            w = word_at(a);
            exp_a.push_back(a);
            if (fwd) begin
                exp_s.push_back(w[15:0]);
                exp_s.push_back(w[31:16]);
                a = (a == END_A) ? START_A : a + 23'd1;
            end else begin
                exp_s.push_back(w[31:16]);
                exp_s.push_back(w[15:0]);
                a = (a == START_A) ? END_A : a - 23'd1;
            end
        end
        exp_a.push_back(a);
    endfunction

    // Flash slave and observers, all sampled on the falling edge.
    initial begin
        flash_if.flash_waitrequest   = 1'b0;
        flash_if.flash_readdata      = '0;
        flash_if.flash_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            if (audio_valid) got_q.push_back(audio_data);
            if (audio_valid && prev_valid) viol++;
            prev_valid = audio_valid;
            if (reset && prev_rd_wait && (!flash_if.flash_read || flash_if.flash_address != prev_addr)) viol++;
            if (flash_if.flash_read && lat_left > 0) viol++;
            flash_if.flash_readdatavalid = 1'b0;
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    flash_if.flash_readdatavalid = 1'b1;
                    flash_if.flash_readdata      = word_at(acc_addr);
                    rdv_count++;
                end
            end
            if (flash_if.flash_read) begin
                if (wcnt > 0) begin
                    flash_if.flash_waitrequest = 1'b1;
                    wcnt--;
                end else begin
                    flash_if.flash_waitrequest = 1'b0;
                    acc_addr = flash_if.flash_address;
                    acc_q.push_back(acc_addr);
                    lat_left = lat_cfg;
                end
            end else begin
                flash_if.flash_waitrequest = 1'b0;
                wcnt = wait_cfg;
            end
            prev_rd_wait = flash_if.flash_read && flash_if.flash_waitrequest;
            prev_addr    = flash_if.flash_address;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic restart_to(input logic [22:0] a);
        pause = 1'b1;
        initial_address = a;
        rst_cmd = 1'b1;
        cyc(1);
        rst_cmd = 1'b0;
        cyc(20);
        got_q.delete();
        acc_q.delete();
    endtask

    task automatic run_samples(input int n, input int budget, input bit tick_every, input bit rand_pause);
        int cnt;
        int next_tick;
        cnt = 0;
        next_tick = $urandom_range(6, 2);
        while (got_q.size() < n && cnt < budget) begin
            sample_tick = 1'b0;
            if (rand_pause) pause = ($urandom_range(3, 0) == 0);
            if (tick_every) sample_tick = 1'b1;
            else begin
                next_tick--;
                if (next_tick == 0) begin
                    sample_tick = 1'b1;
                    next_tick = $urandom_range(6, 2);
                end
            end
            cyc(1);
            cnt++;
        end
        sample_tick = 1'b0;
        if (rand_pause) pause = 1'b0;
        compared++;
        if (got_q.size() < n) begin
            mismatched++;
            $display("FAIL sample_timeout: got %0d samples, required %0d", got_q.size(), n);
        end
    endtask

    task automatic check_stream(input string name, input int nwords, input bit want_next);
        logic [15:0] gs;
        logic [22:0] ga;
        int          na;
        for (int i = 0; i < 2 * nwords; i++) begin
            gs = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            compared++;
            if (gs !== exp_s[i]) begin
                mismatched++;
                $display("FAIL %s sample[%0d]: got %h required %h", name, i, gs, exp_s[i]);
            end
        end
        compared++;
        if (got_q.size() != 2 * nwords) begin
            mismatched++;
            $display("FAIL %s sample_count: got %0d required %0d", name, got_q.size(), 2 * nwords);
        end
        na = want_next ? nwords + 1 : nwords;
        for (int i = 0; i < na; i++) begin
            ga = (i < acc_q.size()) ? acc_q[i] : 23'hxxxxxx;
            compared++;
            if (ga !== exp_a[i]) begin
                mismatched++;
                $display("FAIL %s read_addr[%0d]: got %h required %h", name, i, ga, exp_a[i]);
            end
        end
        if (!want_next) begin
            compared++;
            if (acc_q.size() != nwords) begin
                mismatched++;
                $display("FAIL %s read_count: got %0d required %0d", name, acc_q.size(), nwords);
            end
        end
        exp_last = exp_s[2 * nwords - 1];
    endtask

    task automatic test_reset();
        sample_tick = 1'b0;
        rst_cmd = 1'b0;
        direction = 1'b1;
        pause = 1'b1;
        initial_address = '0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cyc(3);
        compared += 5;
        if (flash_if.flash_read !== 1'b0) begin mismatched++; $display("FAIL reset_read: got %b required 0", flash_if.flash_read); end
        if (flash_if.flash_address !== 23'h0) begin mismatched++; $display("FAIL reset_addr: got %h required 0", flash_if.flash_address); end
        if (audio_data !== 16'h0) begin mismatched++; $display("FAIL reset_audio: got %h required 0", audio_data); end
        if (audio_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b required 0", audio_valid); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", done); end
        reset = 1'b1;
        cyc(4);
        compared++;
        if (flash_if.flash_read !== 1'b0) begin mismatched++; $display("FAIL paused_idle_read: got %b required 0", flash_if.flash_read); end
    endtask

    task automatic test_forward();
        mem[0] = 32'hBBBB_AAAA;
        wait_cfg = 2;
        lat_cfg = 1;
        direction = 1'b1;
        cyc(1);
        pause = 1'b0;
        run_samples(2, 300, 1'b0, 1'b0);
        cyc(15);
        build_exp(23'h0, 1'b1, 1);
        check_stream("forward", 1, 1'b1);
    endtask

    task automatic test_backward();
        mem[int'(END_A)] = 32'h2222_1111;
        restart_to(END_A);
        wait_cfg = 1;
        direction = 1'b0;
        cyc(1);
        pause = 1'b0;
        run_samples(2, 300, 1'b0, 1'b0);
        cyc(15);
        build_exp(END_A, 1'b0, 1);
        check_stream("backward", 1, 1'b1);
    endtask

    task automatic test_end_boundary();
        logic [22:0] st;
        bit          fwd;
        for (int c = 0; c < 2; c++) begin
            st  = (c == 0) ? END_A : START_A;
            fwd = (c == 0);
            restart_to(st);
            wait_cfg = 0;
            direction = fwd;
            cyc(1);
            pause = 1'b0;
            run_samples(2, 300, 1'b0, 1'b0);
            cyc(15);
            build_exp(st, fwd, 1);
`ifdef MUSIC_SEQ_LOOP_EN
            check_stream("boundary_loop", 1, 1'b1);
            compared++;
            if (done !== 1'b0) begin mismatched++; $display("FAIL boundary_loop_done: got %b required 0", done); end
`else
            check_stream("boundary_stop", 1, 1'b0);
            compared += 2;
            if (done !== 1'b1) begin mismatched++; $display("FAIL boundary_done: got %b required 1", done); end
            if (flash_if.flash_read !== 1'b0) begin mismatched++; $display("FAIL boundary_read: got %b required 0", flash_if.flash_read); end
`endif
        end
        restart_to(23'h5);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL restart_clears_done: got %b required 0", done); end
    endtask

    task automatic test_pause_play();
        int          c0;
        int          t;
        logic [31:0] w;
        restart_to(23'h1234);
        wait_cfg = 0;
        lat_cfg = 2;
        direction = 1'b1;
        cyc(1);
        c0 = rdv_count;
        pause = 1'b0;
        t = 0;
        while (rdv_count == c0 && t < 50) begin
            cyc(1);
            t++;
        end
        compared++;
        if (rdv_count == c0) begin mismatched++; $display("FAIL pause_read_timeout: got 0 data beats required 1"); end
        cyc(2);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_tick = 1'b1;
            cyc(1);
            sample_tick = 1'b0;
            cyc(2);
        end
        compared += 2;
        if (got_q.size() != 0) begin mismatched++; $display("FAIL pause_no_valid: got %0d strobes required 0", got_q.size()); end
        if (audio_data !== exp_last) begin mismatched++; $display("FAIL pause_hold: got %h required %h", audio_data, exp_last); end
        pause = 1'b0;
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        cyc(2);
        w = word_at(23'h1234);
        compared += 2;
        if (got_q.size() != 1) begin mismatched++; $display("FAIL unpause_count: got %0d required 1", got_q.size()); end
        else if (got_q[0] !== w[15:0]) begin mismatched++; $display("FAIL unpause_sample: got %h required %h", got_q[0], w[15:0]); end
        if (audio_data !== w[15:0]) begin mismatched++; $display("FAIL unpause_data: got %h required %h", audio_data, w[15:0]); end
    endtask

    task automatic test_rst_in_wait();
        int t;
        int c0;
        mem[32'h100] = $urandom;
        mem[32'h2000] = $urandom;
        restart_to(23'h2000);
        wait_cfg = 1;
        lat_cfg = 4;
        direction = 1'b1;
        initial_address = 23'h100;
        cyc(1);
        c0 = rdv_count;
        pause = 1'b0;
        t = 0;
        while (acc_q.size() == 0 && t < 50) begin
            cyc(1);
            t++;
        end
        cyc(1);
        rst_cmd = 1'b1;
        cyc(1);
        rst_cmd = 1'b0;
        run_samples(2, 300, 1'b0, 1'b0);
        cyc(15);
        compared += 2;
        if (rdv_count - c0 < 2) begin mismatched++; $display("FAIL rst_wait_completed: got %0d beats required >=2", rdv_count - c0); end
        if (acc_q.size() == 0 || acc_q[0] !== 23'h2000) begin
            mismatched++;
            $display("FAIL rst_wait_first_read: got %0d reads required first at 2000", acc_q.size());
        end
        if (acc_q.size() > 0) void'(acc_q.pop_front());
        build_exp(23'h100, 1'b1, 1);
        check_stream("rst_in_wait", 1, 1'b1);
    endtask

    task automatic test_random();
        logic [22:0] st;
        bit          fwd;
        int          nw;
        for (int r = 0; r < 6; r++) begin
            st  = 23'($urandom_range(32'h7FFF0, 32'h10));
            fwd = 1'($urandom_range(1, 0));
            nw  = $urandom_range(4, 2);
            for (int i = 0; i <= nw; i++) begin
                mem[fwd ? int'(st) + i : int'(st) - i] = $urandom;
            end
            restart_to(st);
            wait_cfg = $urandom_range(3, 0);
            lat_cfg = $urandom_range(3, 1);
            direction = fwd;
            cyc(1);
            pause = 1'b0;
            run_samples(2 * nw, 2000, 1'b0, 1'b1);
            cyc(20);
            build_exp(st, fwd, nw);
            check_stream("random", nw, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        restart_to(23'h300);
        wait_cfg = 0;
        lat_cfg = 1;
        direction = 1'b1;
        cyc(1);
        pause = 1'b0;
        run_samples(6, 500, 1'b1, 1'b0);
        cyc(15);
        build_exp(23'h300, 1'b1, 3);
        check_stream("back_to_back", 3, 1'b1);
    endtask

    task automatic test_reset_mid_req();
        int t;
        restart_to(23'h40);
        wait_cfg = 10;
        cyc(1);
        pause = 1'b0;
        t = 0;
        while (flash_if.flash_read !== 1'b1 && t < 50) begin
            cyc(1);
            t++;
        end
        compared++;
        if (flash_if.flash_read !== 1'b1) begin mismatched++; $display("FAIL mid_req_start: got %b required 1", flash_if.flash_read); end
        cyc(2);
        #2;
        reset = 1'b0;
        #1;
        compared += 5;
        if (flash_if.flash_read !== 1'b0) begin mismatched++; $display("FAIL async_read: got %b required 0", flash_if.flash_read); end
        if (flash_if.flash_address !== 23'h0) begin mismatched++; $display("FAIL async_addr: got %h required 0", flash_if.flash_address); end
        if (audio_data !== 16'h0) begin mismatched++; $display("FAIL async_audio: got %h required 0", audio_data); end
        if (audio_valid !== 1'b0) begin mismatched++; $display("FAIL async_valid: got %b required 0", audio_valid); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL async_done: got %b required 0", done); end
        cyc(1);
        pause = 1'b1;
        wait_cfg = 0;
        reset = 1'b1;
        cyc(3);
        got_q.delete();
        acc_q.delete();
        direction = 1'b1;
        pause = 1'b0;
        run_samples(2, 300, 1'b0, 1'b0);
        cyc(15);
        build_exp(START_A, 1'b1, 1);
        check_stream("after_reset", 1, 1'b1);
    endtask

    task automatic test_protocol();
        compared++;
        if (viol != 0) begin
            mismatched++;
            $display("FAIL protocol: got %0d violations required 0", viol);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_forward();
        test_backward();
        test_end_boundary();
        test_pause_play();
        test_rst_in_wait();
        test_random();
        test_back_to_back();
        test_reset_mid_req();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/music_addr_sequencer.md
MUSIC_ADDR_SEQUENCER -- requirements
Module: music_addr_sequencer

Interface
REQ-001 SHALL have parameter START_ADDR, default 23'h0, first 32-bit word of music data.
REQ-002 SHALL have parameter END_ADDR, default 23'h7FFFF, last 32-bit word of music data.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle audio-rate strobe, already synchronous to clk.
REQ-006 SHALL have port rst_cmd  input  1  restart request from keyboard controller, level, sampled each clk.
REQ-007 SHALL have port direction  input  1  1 = forward, 0 = backward.
REQ-008 SHALL have port pause  input  1  1 = hold playback.
REQ-009 SHALL have port initial_address  input  23  reload address applied on restart.
REQ-010 SHALL have port flash_read  output  1  Avalon-MM read request.
REQ-011 SHALL have port flash_address  output  23  word address of the current read.
REQ-012 SHALL have port flash_waitrequest  input  1  slave not ready; read held while high.
REQ-013 SHALL have port flash_readdata  input  32  two packed 16-bit samples, low half first in time.
REQ-014 SHALL have port flash_readdatavalid  input  1  readdata valid strobe.
REQ-015 SHALL have port audio_data  output  16  current signed sample to codec.
REQ-016 SHALL have port audio_valid  output  1  one-cycle strobe, audio_data updated.
REQ-017 SHALL have port done  output  1  end of data reached (non-loop build only).

Function
REQ-018 SHALL implement states IDLE, REQ, WAIT_DATA, PLAY_FIRST, PLAY_SECOND, ADVANCE, DONE.
REQ-019 IDLE -> REQ when pause=0; stays in IDLE while pause=1.
REQ-020 REQ: flash_read=1, flash_address=addr; -> WAIT_DATA on first cycle with flash_waitrequest=0; flash_read deasserts the following cycle.
REQ-021 WAIT_DATA: on flash_readdatavalid, latch the 32-bit word and -> PLAY_FIRST.
REQ-022 PLAY_FIRST: on sample_tick with pause=0, drive the first sample (forward: [15:0], backward: [31:16]), pulse audio_valid next cycle, -> PLAY_SECOND.
REQ-023 PLAY_SECOND: same for the other half; -> ADVANCE.
REQ-024 sample_tick SHALL be ignored while pause=1; audio_data holds its last value.
REQ-025 ADVANCE: forward addr+1, backward addr-1, direction sampled in this cycle; -> IDLE.
REQ-026 Forward at addr==END_ADDR and backward at addr==START_ADDR SHALL follow REQ-041/042.
REQ-027 rst_cmd=1 SHALL set a pending flag; in IDLE, PLAY_FIRST, PLAY_SECOND, ADVANCE the restart applies next cycle: addr<=initial_address, done<=0, -> IDLE.
REQ-028 rst_cmd in REQ or WAIT_DATA SHALL not abort the bus: the read completes, data is discarded, then the restart applies.
REQ-029 At most one read outstanding; flash_read never asserted in WAIT_DATA.
REQ-030 audio_valid SHALL be exactly one cycle per sample; never two in consecutive cycles.

Reset
REQ-031 reset=0 SHALL asynchronously force: state IDLE, addr START_ADDR, flash_read 0, flash_address 0, audio_data 0, audio_valid 0, done 0, pending flag 0.
REQ-032 Reset release SHALL take effect on the next clk edge; first read no earlier than 1 cycle after release.

Configuration
REQ-040 Macro MUSIC_SEQ_LOOP_EN SHALL select end-of-data behaviour.
REQ-041 Defined: forward END_ADDR wraps to START_ADDR, backward START_ADDR wraps to END_ADDR; done tied 0, DONE unreachable.
REQ-042 Undefined: at the boundary -> DONE, done=1, no further reads; only rst_cmd or reset leaves DONE.

Structure
REQ-050 Package music_pkg SHALL hold the state enum, 23-bit address typedef, and default START/END constants.
REQ-051 Sample selection (word + direction + phase -> 16-bit sample) SHALL be sub-module sample_unpacker, purely combinational.

Verification
REQ-060 Forward, waitrequest 2 cycles, readdata 32'hBBBB_AAAA -> audio_data 16'hAAAA then 16'hBBBB on successive ticks, next address 1.
REQ-061 Backward from 23'h7FFFF, readdata 32'h2222_1111 -> 16'h2222 then 16'h1111, next address 23'h7FFFE.
REQ-062 Forward at END_ADDR: loop build -> next flash_address 0; non-loop build -> done=1, flash_read stays 0.
REQ-063 pause=1 in PLAY_FIRST across 5 ticks -> no audio_valid; pause=0 -> sample on next tick.
REQ-064 rst_cmd during WAIT_DATA with initial_address 23'h100 -> read completes, no audio_valid from it, next flash_address 23'h100.
REQ-065 reset asserted mid-REQ -> flash_read 0 immediately, all outputs at reset values without a clk edge.
